// File: rtl/risc_pkg.sv
// risc_pkg: shared fetch-stage types and constants.
package risc_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, FULL, SQUASH} fetch_state_t;
   localparam int INSTR_BYTES = 4;
   localparam logic [63:0] PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {pc, instr} holding register used while the output latch is stalled.
module fetch_skid_buffer #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_drop,
   input  logic               i_unload,
   input  logic [ADDR_W-1:0]  i_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic               o_valid,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr
);
   logic               r_valid;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else if (i_drop || i_unload) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end
   end
   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and one-outstanding instruction fetch with a stallable output latch.
// Define FETCH_PERF_CNT_EN to build the fetched/squashed performance counters.
module fetch_unit
   import risc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               isbranchtaken,
   input  logic [ADDR_W-1:0]  branchpc,
   input  logic               of_stall,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_squashed
);
   localparam logic [ADDR_W-1:0] W_ALIGN = ADDR_W'(PC_ALIGN_MASK);
   localparam logic [ADDR_W-1:0] W_STEP  = ADDR_W'(INSTR_BYTES);

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_pc, r_if_pc;
   logic [INSTR_W-1:0] r_if_instr;
   logic               r_if_valid;
   logic               w_slot_free, w_wait_rsp, w_skid_load, w_unload, w_load, w_skid_valid;
   logic [ADDR_W-1:0]  w_skid_pc;
   logic [INSTR_W-1:0] w_skid_instr;

   assign w_slot_free = !r_if_valid || !of_stall;
   assign w_wait_rsp  = r_state == WAIT && imem_valid && !isbranchtaken;
   assign w_skid_load = w_wait_rsp && !w_slot_free;
   assign w_unload    = r_state == FULL && w_skid_valid && w_slot_free && !isbranchtaken;
   assign w_load      = (w_wait_rsp && w_slot_free) || w_unload;

   fetch_skid_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_skid_load),
      .i_drop   (isbranchtaken),
      .i_unload (w_unload),
      .i_pc     (r_pc),
      .i_instr  (imem_rdata),
      .o_valid  (w_skid_valid),
      .o_pc     (w_skid_pc),
      .o_instr  (w_skid_instr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC & W_ALIGN;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= '0;
      end else if (isbranchtaken) begin
         // a read issued in IDLE or still pending in WAIT/SQUASH must be drained in SQUASH
         r_state    <= (r_state == FULL || (r_state != IDLE && imem_valid)) ? IDLE : SQUASH;
         r_pc       <= branchpc & W_ALIGN;
         r_if_valid <= 1'b0;
      end else begin
         if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_unload ? w_skid_pc : r_pc;
            r_if_instr <= w_unload ? w_skid_instr : imem_rdata;
            r_pc       <= r_pc + W_STEP;
         end else if (!of_stall) begin
            r_if_valid <= 1'b0;
         end
         case (r_state)
            IDLE:    r_state <= WAIT;
            WAIT:    if (imem_valid) r_state <= w_slot_free ? IDLE : FULL;
            FULL:    if (w_unload) r_state <= IDLE;
            default: if (imem_valid) r_state <= IDLE;
         endcase
      end
   end

   assign imem_req  = rst_n && r_state == IDLE;
   assign imem_addr = r_pc;
   assign if_valid  = r_if_valid;
   assign if_pc     = r_if_pc;
   assign if_instr  = r_if_instr;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetched, r_squashed;
   logic [1:0]  w_drops;
   assign w_drops = {1'b0, isbranchtaken && r_if_valid && of_stall}
                  + {1'b0, isbranchtaken && w_skid_valid}
                  + {1'b0, imem_valid && (r_state == SQUASH || (r_state == WAIT && isbranchtaken))};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetched  <= '0;
         r_squashed <= '0;
      end else begin
         r_fetched  <= r_fetched + 32'(w_load);
         r_squashed <= r_squashed + 32'(w_drops);
      end
   end
   assign perf_fetched  = r_fetched;
   assign perf_squashed = r_squashed;
`else
   assign perf_fetched  = '0;
   assign perf_squashed = '0;
`endif
endmodule
